// File: rtl/layer4_argmax_ctrl.sv
// Layer 4 readout: signed running argmax over temp BRAM, result held on valid/ready, then temp clear.
// Result valid NUM_CLASS+RD_LATENCY+1 cycles after start; stalls in OUT while ready_i=0. Macro ARGMAX_AUTO_CLEAR_EN enables CLEAR.
module layer4_argmax_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CLASS  = 10,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  output logic                  temp_rd_en_o,
  output logic [ADDR_WIDTH-1:0] temp_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] temp_data_i,
  output logic                  temp_clear_o,
  output logic [3:0]            class_o,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3
`ifdef ARGMAX_AUTO_CLEAR_EN
    , CLEAR = 3'd4
`endif
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_CLASS - 1);

  state_t                 state, nxt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [RD_LATENCY-1:0]  en_sr;
  logic [ADDR_WIDTH-1:0]  idx_sr [RD_LATENCY];
  logic                   smp_vld;
  logic [ADDR_WIDTH-1:0]  smp_idx;

  assign smp_vld        = en_sr[RD_LATENCY-1];
  assign smp_idx        = idx_sr[RD_LATENCY-1];
  assign temp_rd_addr_o = addr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start_i) nxt = READ;
      READ:  if (addr == LAST) nxt = DRAIN;
      DRAIN: if (smp_vld && smp_idx == LAST) nxt = OUT;
`ifdef ARGMAX_AUTO_CLEAR_EN
      OUT:   if (ready_i) nxt = CLEAR;
      CLEAR: nxt = IDLE;
`else
      OUT:   if (ready_i) nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    temp_rd_en_o = (state == READ);
    valid_o      = (state == OUT);
    busy_o       = (state != IDLE);
`ifdef ARGMAX_AUTO_CLEAR_EN
    temp_clear_o = (state == CLEAR);
`else
    temp_clear_o = 1'b0;
`endif
  end

  // Address holds at the last class once READ ends; it is rezeroed on the next start.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                          addr <= '0;
    else if (state == IDLE && start_i)    addr <= '0;
    else if (state == READ && addr != LAST) addr <= addr + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_sr <= '0;
      for (int i = 0; i < RD_LATENCY; i++) idx_sr[i] <= '0;
    end else begin
      en_sr[0]  <= temp_rd_en_o;
      idx_sr[0] <= addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        en_sr[i]  <= en_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      class_o <= '0;
      max_o   <= '0;
    end else if (smp_vld && (smp_idx == '0 || $signed(temp_data_i) > $signed(max_o))) begin
      class_o <= 4'(smp_idx);
      max_o   <= temp_data_i;
    end
  end

endmodule

// File: tb/tb_layer4_argmax_ctrl.sv
// Bench for layer4_argmax_ctrl: two instances (read latency 1 and 2) share stimulus and a temp BRAM image.
module tb_layer4_argmax_ctrl;

  localparam int NUM = 10;
`ifdef ARGMAX_AUTO_CLEAR_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic clk = 1'b0;
  logic rstn, start, ready;
  logic       en1, clr1, vld1, busy1, en2, clr2, vld2, busy2;
  logic [5:0] ad1, ad2;
  logic [7:0] d1, d2, m1, m2, pipe2;
  logic [3:0] c1, c2;

  logic [7:0]        mem [64];
  logic signed [7:0] sc  [NUM];
  int                exp_cls;
  logic [7:0]        exp_max;
  int                total = 0;
  int                bad = 0;

  always #5 clk = ~clk;

  layer4_argmax_ctrl u1 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .temp_rd_en_o(en1), .temp_rd_addr_o(ad1),
    .temp_data_i(d1), .temp_clear_o(clr1), .class_o(c1), .max_o(m1), .valid_o(vld1),
    .ready_i(ready), .busy_o(busy1));

  layer4_argmax_ctrl #(.RD_LATENCY(2)) u2 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .temp_rd_en_o(en2), .temp_rd_addr_o(ad2),
    .temp_data_i(d2), .temp_clear_o(clr2), .class_o(c2), .max_o(m2), .valid_o(vld2),
    .ready_i(ready), .busy_o(busy2));

  // Temp BRAM models; unread cycles return junk so stray captures show up.
  always @(posedge clk) begin
    d1    <= en1 ? mem[ad1] : 8'($urandom);
    pipe2 <= en2 ? mem[ad2] : 8'($urandom);
    d2    <= pipe2;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int v[NUM]);
    for (int i = 0; i < NUM; i++) sc[i] = 8'(v[i]);
  endtask

  task automatic load_rand(input int lo, input int hi);
    for (int i = 0; i < NUM; i++) sc[i] = 8'($urandom_range(hi - lo) + lo);
  endtask

  // Argmax from the score list: first index wins ties.
  task automatic model();
    logic signed [7:0] best;
    best = sc[0];
    exp_cls = 0;
    for (int i = 1; i < NUM; i++)
      if (sc[i] > best) begin
        best = sc[i];
        exp_cls = i;
      end
    exp_max = best;
    for (int i = 0; i < NUM; i++) mem[i] = sc[i];
  endtask

  // t counts cycles after the edge that sampled start; ron is the first cycle with ready high.
  task automatic check_dut(input string n, input int t, input int lat, input int ron,
                           input logic en, input logic [5:0] ad, input logic clr,
                           input logic [3:0] c, input logic [7:0] m, input logic v, input logic b);
    int vs, hs;
    vs = NUM + lat + 1;
    hs = (ron > vs) ? ron : vs;
    chk({n, ".rd_en"}, int'(en), int'(t >= 1 && t <= NUM));
    if (t >= 1 && t <= NUM) chk({n, ".addr"}, int'(ad), t - 1);
    chk({n, ".valid"}, int'(v), int'(t >= vs && t <= hs));
    chk({n, ".clear"}, int'(clr), int'(AUTO == 1 && t == hs + 1));
    chk({n, ".busy"}, int'(b), int'(t >= 1 && t <= hs + AUTO));
    if (t >= vs && t <= hs) begin
      chk({n, ".class"}, int'(c), exp_cls);
      chk({n, ".max"}, int'(m), int'(exp_max));
    end
  endtask

  task automatic check_zero(input string n, input logic en, input logic [5:0] ad, input logic clr,
                            input logic [3:0] c, input logic [7:0] m, input logic v, input logic b);
    chk({n, ".rst_en"}, int'(en), 0);
    chk({n, ".rst_addr"}, int'(ad), 0);
    chk({n, ".rst_clear"}, int'(clr), 0);
    chk({n, ".rst_class"}, int'(c), 0);
    chk({n, ".rst_max"}, int'(m), 0);
    chk({n, ".rst_valid"}, int'(v), 0);
    chk({n, ".rst_busy"}, int'(b), 0);
  endtask

  // Entered just after a rising edge with both instances idle; returns the same way.
  task automatic run_image(input int stall, input bit poke);
    int ron, hs2, last;
    model();
    ron  = (stall == 0) ? 0 : NUM + 2 + stall;
    hs2  = (ron > NUM + 3) ? ron : NUM + 3;
    last = hs2 + 1 + AUTO;
    start = 1'b1;
    ready = (ron == 0);
    @(posedge clk); #1;
    for (int t = 1; t <= last; t++) begin
      ready = (t >= ron);
      start = poke && (t == 20);
      @(negedge clk);
      check_dut("lat1", t, 1, ron, en1, ad1, clr1, c1, m1, vld1, busy1);
      check_dut("lat2", t, 2, ron, en2, ad2, clr2, c2, m2, vld2, busy2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  task automatic run_reset();
    load_rand(-128, 127);
    model();
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      check_dut("lat1", t, 1, 0, en1, ad1, clr1, c1, m1, vld1, busy1);
      check_dut("lat2", t, 2, 0, en2, ad2, clr2, c2, m2, vld2, busy2);
      if (t < 6) begin
        @(posedge clk); #1;
      end
    end
    rstn = 1'b0;
    #1;
    check_zero("lat1", en1, ad1, clr1, c1, m1, vld1, busy1);
    check_zero("lat2", en2, ad2, clr2, c2, m2, vld2, busy2);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_zero("lat1", en1, ad1, clr1, c1, m1, vld1, busy1);
    check_zero("lat2", en2, ad2, clr2, c2, m2, vld2, busy2);
    rstn = 1'b1;
    @(posedge clk); #1;

    load('{3, -5, 7, 2, 0, 1, -1, 6, 4, 5});
    run_image(0, 1'b0);
    load('{9, 9, 9, 9, 9, 9, 9, 9, 9, 9});
    run_image(0, 1'b0);
    load('{-128, -100, -50, -20, -10, -3, -2, -7, -128, -9});
    run_image(0, 1'b0);
    load('{3, -5, 7, 2, 0, 1, -1, 6, 4, 5});
    run_image(20, 1'b1);

    run_reset();
    load_rand(-128, 127);
    run_image(0, 1'b0);

    load_rand(-128, 126);
    sc[9] = 8'sd127;
    run_image(0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      if (n % 3 == 0) load_rand(-3, 3);
      else            load_rand(-128, 127);
      run_image(int'($urandom_range(4)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer4_argmax_ctrl.md
# layer4_argmax_ctrl

Controller that sequences readout of the final-layer (layer 4) temp BRAM once the layer has finished accumulating. On a start pulse it walks the class scores by address and tracks a running signed maximum. It then presents the winning class index through a valid/ready handshake and clears the temp BRAM for the next image. It sits between the layer 4 block (driving its `temp_rd_addr`, `temp_rd_en` and `temp_clear` inputs) and the result/output logic of the MNIST pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of one temp BRAM score, signed two's complement.
- `NUM_CLASS`, 10, number of scores read, at addresses 0..NUM_CLASS-1.
- `ADDR_WIDTH`, 6, temp BRAM read address width.
- `RD_LATENCY`, 1, cycles from `temp_rd_en_o` to valid `temp_data_i`.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  one-cycle pulse: layer 4 results complete in temp BRAM.
- `temp_rd_en_o`  out  1  temp BRAM read enable.
- `temp_rd_addr_o`  out  ADDR_WIDTH  temp BRAM read address.
- `temp_data_i`  in  DATA_WIDTH  temp BRAM read data.
- `temp_clear_o`  out  1  one-cycle temp BRAM clear pulse.
- `class_o`  out  4  argmax class index.
- `max_o`  out  DATA_WIDTH  winning score.
- `valid_o`  out  1  `class_o`/`max_o` valid.
- `ready_i`  in  1  consumer accepts the result.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, READ, DRAIN, OUT, CLEAR.
- IDLE: on `start_i`=1, go to READ and zero the address counter. `start_i` is ignored in all other states, with no queuing.
- READ: `temp_rd_en_o`=1 with `temp_rd_addr_o`=0,1,…,NUM_CLASS-1, one address per cycle. After NUM_CLASS cycles, go to DRAIN.
- Capture: a shift register of depth RD_LATENCY delays the read enable and the index. A sample is valid when the delayed enable is 1.
  - The first valid sample (index 0) loads the maximum and class unconditionally.
  - Each later sample replaces them only if it is strictly greater, using a signed compare. Ties keep the lowest index.
- DRAIN: stay RD_LATENCY cycles until the last sample is captured, then go to OUT.
- OUT: `valid_o`=1. `class_o` and `max_o` are held stable until `ready_i`=1 in the same cycle as `valid_o`. On that handshake, go to CLEAR.
- CLEAR: `temp_clear_o`=1 for exactly one cycle, then go to IDLE.
- Output values: `class_o`/`max_o` keep their last values after the handshake and change only during the next capture. They are undefined for the consumer whenever `valid_o`=0.
- Width rules:
  - The address counter is ADDR_WIDTH bits; NUM_CLASS ≤ 2^ADDR_WIDTH.
  - `class_o` is the zero-extended index.
  - The comparison is a full-width signed comparison with no saturation.

## Timing
- Reset values: `temp_rd_en_o`=0, `temp_rd_addr_o`=0, `temp_clear_o`=0, `class_o`=0, `max_o`=0, `valid_o`=0, `busy_o`=0, FSM=IDLE.
- `start_i` is sampled at edge k. `temp_rd_en_o` is high in cycles k+1..k+NUM_CLASS.
- `valid_o` rises at cycle k+NUM_CLASS+RD_LATENCY+1. With the defaults this is k+12.
- If `ready_i` is already high, the handshake completes in the first OUT cycle. `temp_clear_o` is then high in the next cycle, and IDLE follows one cycle later.
- The earliest accepted back-to-back `start_i` is the cycle after CLEAR. Minimum period = NUM_CLASS+RD_LATENCY+3 cycles.
- Reset asserted mid-operation: all outputs and state return to reset values immediately. No clear pulse is issued, and the temp BRAM contents are the owner's responsibility.
- `temp_rd_en_o` and `temp_clear_o` are never high in the same cycle.

## Configuration
- Macro `ARGMAX_AUTO_CLEAR_EN`.
- Defined: the CLEAR state exists, and `temp_clear_o` pulses after every handshake as described above.
- Undefined:
  - The CLEAR state is removed and the handshake goes OUT→IDLE directly.
  - `temp_clear_o` is tied to 0, so the top-level sequencer owns clearing.
  - The minimum period shrinks by one cycle.

## Test plan
- Reset, then start with scores {3,-5,7,2,0,1,-1,6,4,5} and `ready_i`=1: `temp_rd_en_o` is high for 10 cycles at addresses 0..9. `valid_o` rises at k+12 with `class_o`=2 and `max_o`=7. `temp_clear_o` pulses once, at k+13.
- Tie {9,9,…,9}: `class_o`=0, `max_o`=9. All negative, {-128,…,-2 at index 6,…}: `class_o`=6, `max_o`=-2 (0xFE).
- Backpressure: `ready_i`=0 for 20 cycles after `valid_o`. `valid_o`, `class_o` and `max_o` stay stable, there is no `temp_clear_o`, and a `start_i` pulse during the stall is ignored. Raise `ready_i`: one handshake, then the clear pulse.
- Assert `rstn_i` low at address 5 of READ: all outputs are 0 in the same cycle. After release, a new start yields correct results for new data.
- Set RD_LATENCY=2 with max at index 9 (value 127): `class_o`=9, `max_o`=127, and `valid_o` rises at k+13.
- Build without `ARGMAX_AUTO_CLEAR_EN`: `temp_clear_o` is always 0, and IDLE is re-entered in the cycle after the handshake.
